// File: rtl/bcd_hms_timer.sv
// BCD hh:mm:ss up/down counter with validated preset, wrap, expiry and load-error pulses; optional alarm (BCD_HMS_ALARM_EN).
// Latency: digits and pulses update one clk_1Hz edge after the qualifying input; at_zero is combinational from the digits.
// Backpressure: none; every edge is accepted, priority reset > load > (en ? step : hold).
module bcd_hms_timer #(
    parameter int unsigned MAX_HR      = 23,
    parameter bit          SAT_AT_ZERO = 1'b1
) (
    input  logic       clk_1Hz,
    input  logic       reset,
    input  logic       en,
    input  logic       up_down,
    input  logic       load,
    input  logic [7:0] ld_hr,
    input  logic [7:0] ld_min,
    input  logic [7:0] ld_sec,
`ifdef BCD_HMS_ALARM_EN
    input  logic        alarm_set,
    input  logic [23:0] alarm_val,
    output logic        alarm,
`endif
    output logic [3:0] msb_hr,
    output logic [3:0] lsb_hr,
    output logic [3:0] msb_min,
    output logic [3:0] lsb_min,
    output logic [3:0] msb_sec,
    output logic [3:0] lsb_sec,
    output logic       wrap,
    output logic       expired,
    output logic       load_err,
    output logic       at_zero
);

    localparam logic [3:0] MAX_MSB = 4'(MAX_HR / 10);
    localparam logic [3:0] MAX_LSB = 4'(MAX_HR % 10);
    localparam logic [7:0] MAX_HR8 = 8'(MAX_HR);

    // A preset is legal only if every digit is in its BCD range and the hour fits MAX_HR.
    function automatic logic hms_valid(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        logic [7:0] hv;
        hv = ({4'd0, h[7:4]} * 8'd10) + {4'd0, h[3:0]};
        return (h[3:0] <= 4'd9) && (m[3:0] <= 4'd9) && (s[3:0] <= 4'd9) &&
               (m[7:4] <= 4'd5) && (s[7:4] <= 4'd5) && (hv <= MAX_HR8);
    endfunction

    logic [3:0] n_msb_hr, n_lsb_hr, n_msb_min, n_lsb_min, n_msb_sec, n_lsb_sec;
    logic       step_wrap;
    logic       step_exp;
    logic       hr_max;
    logic       load_ok;

    assign at_zero = ~|{msb_hr, lsb_hr, msb_min, lsb_min, msb_sec, lsb_sec};
    assign hr_max  = (msb_hr == MAX_MSB) && (lsb_hr == MAX_LSB);
    assign load_ok = hms_valid(ld_hr, ld_min, ld_sec);

    // Next value of a one-second step in the current direction, with ripple carry/borrow.
    always_comb begin
        n_msb_hr  = msb_hr;
        n_lsb_hr  = lsb_hr;
        n_msb_min = msb_min;
        n_lsb_min = lsb_min;
        n_msb_sec = msb_sec;
        n_lsb_sec = lsb_sec;
        step_wrap = 1'b0;
        step_exp  = 1'b0;
        if (up_down) begin
            if (lsb_sec != 4'd9) begin
                n_lsb_sec = lsb_sec + 4'd1;
            end else begin
                n_lsb_sec = 4'd0;
                if (msb_sec != 4'd5) begin
                    n_msb_sec = msb_sec + 4'd1;
                end else begin
                    n_msb_sec = 4'd0;
                    if (lsb_min != 4'd9) begin
                        n_lsb_min = lsb_min + 4'd1;
                    end else begin
                        n_lsb_min = 4'd0;
                        if (msb_min != 4'd5) begin
                            n_msb_min = msb_min + 4'd1;
                        end else begin
                            n_msb_min = 4'd0;
                            if (hr_max) begin
                                n_msb_hr  = 4'd0;
                                n_lsb_hr  = 4'd0;
                                step_wrap = 1'b1;
                            end else if (lsb_hr != 4'd9) begin
                                n_lsb_hr = lsb_hr + 4'd1;
                            end else begin
                                n_lsb_hr = 4'd0;
                                n_msb_hr = msb_hr + 4'd1;
                            end
                        end
                    end
                end
            end
        end else if (at_zero) begin
            // Saturating build simply holds; wrapping build jumps to the top of the range.
            if (!SAT_AT_ZERO) begin
                n_msb_hr  = MAX_MSB;
                n_lsb_hr  = MAX_LSB;
                n_msb_min = 4'd5;
                n_lsb_min = 4'd9;
                n_msb_sec = 4'd5;
                n_lsb_sec = 4'd9;
                step_wrap = 1'b1;
            end
        end else begin
            // Only 00:00:01 can reach zero in one down step.
            step_exp = ~|{msb_hr, lsb_hr, msb_min, lsb_min, msb_sec} && (lsb_sec == 4'd1);
            if (lsb_sec != 4'd0) begin
                n_lsb_sec = lsb_sec - 4'd1;
            end else begin
                n_lsb_sec = 4'd9;
                if (msb_sec != 4'd0) begin
                    n_msb_sec = msb_sec - 4'd1;
                end else begin
                    n_msb_sec = 4'd5;
                    if (lsb_min != 4'd0) begin
                        n_lsb_min = lsb_min - 4'd1;
                    end else begin
                        n_lsb_min = 4'd9;
                        if (msb_min != 4'd0) begin
                            n_msb_min = msb_min - 4'd1;
                        end else begin
                            n_msb_min = 4'd5;
                            // Value is non-zero here, so the hour is non-zero as well.
                            if (lsb_hr != 4'd0) begin
                                n_lsb_hr = lsb_hr - 4'd1;
                            end else begin
                                n_lsb_hr = 4'd9;
                                n_msb_hr = msb_hr - 4'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    // Digit registers and single-cycle status pulses: reset, then load, then step or hold.
    always_ff @(posedge clk_1Hz) begin
        if (reset) begin
            msb_hr   <= 4'd0;
            lsb_hr   <= 4'd0;
            msb_min  <= 4'd0;
            lsb_min  <= 4'd0;
            msb_sec  <= 4'd0;
            lsb_sec  <= 4'd0;
            wrap     <= 1'b0;
            expired  <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap     <= 1'b0;
            expired  <= 1'b0;
            load_err <= 1'b0;
            if (load) begin
                if (load_ok) begin
                    {msb_hr, lsb_hr}   <= ld_hr;
                    {msb_min, lsb_min} <= ld_min;
                    {msb_sec, lsb_sec} <= ld_sec;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (en) begin
                msb_hr   <= n_msb_hr;
                lsb_hr   <= n_lsb_hr;
                msb_min  <= n_msb_min;
                lsb_min  <= n_lsb_min;
                msb_sec  <= n_msb_sec;
                lsb_sec  <= n_lsb_sec;
                wrap     <= step_wrap;
                expired  <= step_exp;
            end
        end
    end

`ifdef BCD_HMS_ALARM_EN
    logic [23:0] alarm_reg;
    logic        armed;
    logic [23:0] cur_val;
    logic [23:0] nxt_val;

    assign cur_val = {msb_hr, lsb_hr, msb_min, lsb_min, msb_sec, lsb_sec};
    assign nxt_val = {n_msb_hr, n_lsb_hr, n_msb_min, n_lsb_min, n_msb_sec, n_lsb_sec};

    // Alarm fires only when a real count step moves the digits onto the armed value; loads never fire it.
    always_ff @(posedge clk_1Hz) begin
        if (reset) begin
            alarm_reg <= 24'd0;
            armed     <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            alarm <= !load && en && armed && (nxt_val != cur_val) && (nxt_val == alarm_reg);
            if (alarm_set && hms_valid(alarm_val[23:16], alarm_val[15:8], alarm_val[7:0])) begin
                alarm_reg <= alarm_val;
                armed     <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bcd_hms_timer.sv
// Scoreboard bench: two timer instances (24 h saturating, 13 h wrapping) share one stimulus stream.
// Expected outputs come from a seconds-count reference model and are queued per instance.
// A monitor pops one entry per clock and compares it against the registered outputs.
module tb_bcd_hms_timer;

    typedef logic [28:0] exp_t;   // {digits[23:0], wrap, expired, load_err, at_zero, alarm}

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, en, up_down, load;
    logic [7:0]  ld_hr, ld_min, ld_sec;
    logic        alarm_set;
    logic [23:0] alarm_val;

    logic [3:0] mh [2], lh [2], mm [2], lm [2], ms [2], ls [2];
    logic       wr [2], ex [2], le [2], az [2], al [2];

    bcd_hms_timer #(.MAX_HR(23), .SAT_AT_ZERO(1'b1)) u_h23 (
        .clk_1Hz(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
        .ld_hr(ld_hr), .ld_min(ld_min), .ld_sec(ld_sec),
`ifdef BCD_HMS_ALARM_EN
        .alarm_set(alarm_set), .alarm_val(alarm_val), .alarm(al[0]),
`endif
        .msb_hr(mh[0]), .lsb_hr(lh[0]), .msb_min(mm[0]), .lsb_min(lm[0]),
        .msb_sec(ms[0]), .lsb_sec(ls[0]),
        .wrap(wr[0]), .expired(ex[0]), .load_err(le[0]), .at_zero(az[0])
    );

    bcd_hms_timer #(.MAX_HR(12), .SAT_AT_ZERO(1'b0)) u_h12 (
        .clk_1Hz(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
        .ld_hr(ld_hr), .ld_min(ld_min), .ld_sec(ld_sec),
`ifdef BCD_HMS_ALARM_EN
        .alarm_set(alarm_set), .alarm_val(alarm_val), .alarm(al[1]),
`endif
        .msb_hr(mh[1]), .lsb_hr(lh[1]), .msb_min(mm[1]), .lsb_min(lm[1]),
        .msb_sec(ms[1]), .lsb_sec(ls[1]),
        .wrap(wr[1]), .expired(ex[1]), .load_err(le[1]), .at_zero(az[1])
    );

`ifndef BCD_HMS_ALARM_EN
    assign al[0] = 1'b0;
    assign al[1] = 1'b0;
`endif

    // Reference model state: time of day as plain seconds.
    int tm [2];
    int arm [2];
    bit armed [2];
    int mx [2]  = '{23, 12};
    bit sat [2] = '{1'b1, 1'b0};

    exp_t q0 [$];
    exp_t q1 [$];

    int checks = 0;
    int errors = 0;

    function automatic int dec(logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic bit legal(int maxh, logic [7:0] h, logic [7:0] m, logic [7:0] s);
        return (h[3:0] <= 4'd9) && (m[3:0] <= 4'd9) && (s[3:0] <= 4'd9) &&
               (dec(m) <= 59) && (dec(s) <= 59) && (dec(h) <= maxh);
    endfunction

    function automatic logic [7:0] b8(int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [23:0] to_bcd(int t);
        return {b8(t / 3600), b8((t / 60) % 60), b8(t % 60)};
    endfunction

    // One clock of behaviour for instance k, from the current input values.
    task automatic model(input int k, output exp_t e);
        int  old, total;
        bit  w, x, l, a;
        w = 1'b0; x = 1'b0; l = 1'b0; a = 1'b0;
        total = (mx[k] + 1) * 3600;
        if (reset) begin
            tm[k] = 0; arm[k] = 0; armed[k] = 1'b0;
        end else begin
            if (load) begin
                if (legal(mx[k], ld_hr, ld_min, ld_sec))
                    tm[k] = dec(ld_hr) * 3600 + dec(ld_min) * 60 + dec(ld_sec);
                else
                    l = 1'b1;
            end else if (en) begin
                old = tm[k];
                if (up_down) begin
                    tm[k] = (tm[k] + 1) % total;
                    w = (tm[k] == 0);
                end else if (tm[k] == 0) begin
                    if (!sat[k]) begin tm[k] = total - 1; w = 1'b1; end
                end else begin
                    tm[k] = tm[k] - 1;
                    x = (tm[k] == 0);
                end
                a = armed[k] && (tm[k] != old) && (tm[k] == arm[k]);
            end
            if (alarm_set && legal(mx[k], alarm_val[23:16], alarm_val[15:8], alarm_val[7:0])) begin
                arm[k]   = dec(alarm_val[23:16]) * 3600 + dec(alarm_val[15:8]) * 60 + dec(alarm_val[7:0]);
                armed[k] = 1'b1;
            end
        end
`ifndef BCD_HMS_ALARM_EN
        a = 1'b0;
`endif
        e = {to_bcd(tm[k]), w, x, l, (tm[k] == 0), a};
    endtask

    task automatic drive(input bit r, input bit e, input bit u, input bit l,
                         input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                         input bit as, input logic [23:0] av);
        exp_t v0, v1;
        @(negedge clk);
        reset = r; en = e; up_down = u; load = l;
        ld_hr = h; ld_min = m; ld_sec = s;
        alarm_set = as; alarm_val = av;
        model(0, v0); q0.push_back(v0);
        model(1, v1); q1.push_back(v1);
    endtask

    function automatic exp_t actual(int k);
        return {mh[k], lh[k], mm[k], lm[k], ms[k], ls[k], wr[k], ex[k], le[k], az[k], al[k]};
    endfunction

    // Monitor: one expected entry per instance per clock, sampled after the edge settles.
    initial begin
        exp_t want, got;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                want = q0.pop_front(); got = actual(0); checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL h23 t=%0t got hms=%h w/x/le/z/al=%b want hms=%h w/x/le/z/al=%b",
                             $time, got[28:5], got[4:0], want[28:5], want[4:0]);
                end
            end
            if (q1.size() > 0) begin
                want = q1.pop_front(); got = actual(1); checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL h12 t=%0t got hms=%h w/x/le/z/al=%b want hms=%h w/x/le/z/al=%b",
                             $time, got[28:5], got[4:0], want[28:5], want[4:0]);
                end
            end
        end
    end

    initial begin
        bit ud;
        logic [7:0] h, m, s;
        reset = 1'b1; en = 1'b0; up_down = 1'b1; load = 1'b0;
        ld_hr = 8'h00; ld_min = 8'h00; ld_sec = 8'h00;
        alarm_set = 1'b0; alarm_val = 24'h0;

        // Reset wins over load and en.
        drive(1, 1, 1, 1, 8'h12, 8'h34, 8'h56, 0, 24'h0);
        // Up rollover at the top of the day.
        drive(0, 0, 1, 1, 8'h23, 8'h59, 8'h58, 0, 24'h0);
        repeat (3) drive(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 24'h0);
        // Countdown expiry and hold at zero.
        drive(0, 0, 0, 1, 8'h00, 8'h00, 8'h02, 0, 24'h0);
        repeat (4) drive(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 24'h0);
        // Rejected presets.
        drive(0, 1, 1, 1, 8'h01, 8'h60, 8'h00, 0, 24'h0);
        drive(0, 1, 1, 1, 8'h24, 8'h00, 8'h00, 0, 24'h0);
        drive(0, 1, 1, 1, 8'h13, 8'h00, 8'h0A, 0, 24'h0);
        // Hour limit 12 rollover and hour borrow.
        drive(0, 0, 1, 1, 8'h12, 8'h59, 8'h59, 0, 24'h0);
        drive(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 24'h0);
        drive(0, 0, 0, 1, 8'h10, 8'h00, 8'h00, 0, 24'h0);
        drive(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 24'h0);
        // Zero preset does not expire; wrapping instance wraps down from zero.
        drive(0, 1, 0, 1, 8'h00, 8'h00, 8'h00, 0, 24'h0);
        repeat (2) drive(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 24'h0);
`ifdef BCD_HMS_ALARM_EN
        // Arm 00:01:00, start at 00:00:58 counting up.
        drive(0, 0, 1, 1, 8'h00, 8'h00, 8'h58, 1, 24'h000100);
        repeat (4) drive(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 24'h0);
`endif

        ud = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) ud = ~ud;
            case ($urandom_range(0, 3))
                0: begin h = 8'($urandom); m = 8'($urandom); s = 8'($urandom); end
                1: begin h = b8($urandom_range(11, 23)); m = 8'h59; s = b8($urandom_range(55, 59)); end
                2: begin h = 8'h00; m = 8'h00; s = b8($urandom_range(0, 3)); end
                default: begin h = b8($urandom_range(0, 24)); m = b8($urandom_range(0, 60)); s = b8($urandom_range(0, 59)); end
            endcase
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, ud,
                  $urandom_range(0, 7) == 0, h, m, s,
                  $urandom_range(0, 15) == 0, to_bcd(tm[1] + $urandom_range(1, 3)));
        end

        repeat (3) @(negedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d/%0d entries left want 0/0", q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
